// File: rtl/atm_controller_param.sv
// atm_controller_param: parametrised ATM session controller.
// Handles PIN entry and retry blocking. A card session can run several
// deposits, withdrawals and balance queries. Withdrawals are capped by a
// cumulative limit. Card removal and an inactivity timeout abort the session.
// Every output comes from a register.
module atm_controller_param #(
  parameter int unsigned      PIN_DIGITS   = 4,
  parameter int unsigned      MAX_TRIES    = 3,
  parameter int unsigned      BAL_W        = 64,
  parameter int unsigned      AMT_W        = 32,
  parameter logic [AMT_W:0]   WD_LIMIT     = (AMT_W+1)'(100000),
  parameter int unsigned      TIMEOUT_CYC  = 1024,
  parameter logic [BAL_W-1:0] INIT_BALANCE = BAL_W'(1524330493)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    receivedCard,
  input  logic                    stbDigit,
  input  logic [3:0]              digit,
  input  logic [4*PIN_DIGITS-1:0] pin,
  input  logic                    stbTransaction,
  input  logic [1:0]              transType,
  input  logic                    stbAmount,
  input  logic [AMT_W-1:0]        amount,
  input  logic                    clearLimit,
  output logic                    balanceUpdated,
  output logic                    giveMoney,
  output logic                    insufficientFunds,
  output logic                    limitExceeded,
  output logic                    balanceValid,
  output logic [BAL_W-1:0]        balanceOut,
  output logic                    incorrectPin,
  output logic                    warning,
  output logic                    block,
  output logic                    timeout
);

  localparam int PIN_W = 4 * PIN_DIGITS;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] C_FULL       = CNT_W'(PIN_DIGITS);
  localparam logic [CNT_W-1:0] C_LAST_DIGIT = CNT_W'(PIN_DIGITS - 1);
  localparam logic [TRY_W-1:0] C_MAX_TRIES  = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] C_WARN_TRIES = TRY_W'(MAX_TRIES - 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PIN_ENTRY, S_PIN_CHECK, S_MENU,
    S_DEPOSIT, S_WITHDRAW, S_DONE, S_BLOCKED
  } state_t;

  // Registered state
  state_t           r_state;
  logic [BAL_W-1:0] r_balance;
  logic [TRY_W-1:0] r_tries;
  logic [AMT_W:0]   r_wd_total;
  logic [CNT_W-1:0] r_count;
  logic [PIN_W-1:0] r_entry;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [BAL_W-1:0] r_bal_out;
  logic             r_bal_upd, r_give, r_insuf, r_limit, r_bal_valid, r_timeout;
  logic             r_incorrect, r_warning, r_block;

  // Next-state values
  state_t           w_state_next;
  logic [BAL_W-1:0] w_balance_next;
  logic [TRY_W-1:0] w_tries_next;
  logic [AMT_W:0]   w_wd_next;
  logic [CNT_W-1:0] w_count_next;
  logic [PIN_W-1:0] w_entry_next;
  logic [TMO_W-1:0] w_tmo_next;
  logic [BAL_W-1:0] w_bal_out_next;
  logic             w_bal_upd_next, w_give_next, w_insuf_next, w_limit_next;
  logic             w_bal_valid_next, w_timeout_next;
  logic             w_incorrect_next, w_warning_next, w_block_next;

  // Helper terms
  logic             w_card_gone;
  logic             w_any_stb;
  logic             w_counting;
  logic [TRY_W-1:0] w_tries_inc;
  logic [BAL_W-1:0] w_amt_ext;
  logic [BAL_W:0]   w_dep_sum;
  logic [AMT_W:0]   w_wd_base;
  logic [AMT_W+1:0] w_wd_sum;

  assign w_card_gone = !receivedCard && (r_state != S_IDLE) && (r_state != S_BLOCKED);
  assign w_any_stb   = stbDigit | stbTransaction | stbAmount;
  assign w_counting  = (r_state == S_PIN_ENTRY) || (r_state == S_MENU) ||
                       (r_state == S_DEPOSIT) || (r_state == S_WITHDRAW);
  assign w_tries_inc = r_tries + 1'b1;
  assign w_amt_ext   = BAL_W'(amount);
  assign w_dep_sum   = {1'b0, r_balance} + (BAL_W+1)'(amount);
  // A clear on the same edge as a withdrawal commit is applied first.
  assign w_wd_base   = clearLimit ? '0 : r_wd_total;
  assign w_wd_sum    = {1'b0, w_wd_base} + (AMT_W+2)'(amount);

  // Next-state and output decode; card removal pre-empts any state action
  always_comb begin
    w_state_next     = r_state;
    w_balance_next   = r_balance;
    w_tries_next     = r_tries;
    w_wd_next        = w_wd_base;
    w_count_next     = r_count;
    w_entry_next     = r_entry;
    w_tmo_next       = '0;
    w_bal_out_next   = r_bal_out;
    w_bal_upd_next   = 1'b0;
    w_give_next      = 1'b0;
    w_insuf_next     = 1'b0;
    w_limit_next     = 1'b0;
    w_bal_valid_next = 1'b0;
    w_timeout_next   = 1'b0;
    w_incorrect_next = r_incorrect;
    w_warning_next   = r_warning;
    w_block_next     = r_block;

    if (w_card_gone) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_incorrect_next = 1'b0;
          w_warning_next   = 1'b0;
          w_count_next     = '0;
          if (receivedCard) w_state_next = S_PIN_ENTRY;
        end
        S_PIN_ENTRY: begin
          if (stbDigit && (r_count < C_FULL)) begin
            w_entry_next = (r_entry << 4) | PIN_W'(digit);
            w_count_next = r_count + 1'b1;
            if (r_count == C_LAST_DIGIT) w_state_next = S_PIN_CHECK;
          end
        end
        S_PIN_CHECK: begin
          if (r_entry == pin) begin
            w_state_next     = S_MENU;
            w_tries_next     = '0;
            w_incorrect_next = 1'b0;
            w_warning_next   = 1'b0;
          end else begin
            w_tries_next     = w_tries_inc;
            w_incorrect_next = 1'b1;
            w_count_next     = '0;
            if (w_tries_inc == C_WARN_TRIES) w_warning_next = 1'b1;
            if (w_tries_inc == C_MAX_TRIES) begin
              w_state_next = S_BLOCKED;
              w_block_next = 1'b1;
            end else begin
              w_state_next = S_PIN_ENTRY;
            end
          end
        end
        S_MENU: begin
          if (stbTransaction) begin
            case (transType)
              2'b00: w_state_next = S_DEPOSIT;
              2'b01: w_state_next = S_WITHDRAW;
              2'b10: begin
                w_bal_out_next   = r_balance;
                w_bal_valid_next = 1'b1;
                w_state_next     = S_DONE;
              end
              default: w_state_next = S_IDLE;
            endcase
          end
        end
        S_DEPOSIT: begin
          if (stbAmount && (amount != '0)) begin
            w_balance_next = w_dep_sum[BAL_W] ? '1 : w_dep_sum[BAL_W-1:0];
            w_bal_upd_next = 1'b1;
            w_state_next   = S_DONE;
          end
        end
        S_WITHDRAW: begin
          if (stbAmount && (amount != '0)) begin
            w_state_next = S_DONE;
            if (w_amt_ext > r_balance) begin
              w_insuf_next = 1'b1;
            end else if (w_wd_sum > {1'b0, WD_LIMIT}) begin
              w_limit_next = 1'b1;
            end else begin
              w_balance_next = r_balance - w_amt_ext;
              w_wd_next      = w_wd_sum[AMT_W:0];
              w_give_next    = 1'b1;
              w_bal_upd_next = 1'b1;
            end
          end
        end
        S_DONE:    w_state_next = S_MENU;
        S_BLOCKED: w_block_next = 1'b1;
        default:   w_state_next = S_IDLE;
      endcase

      // Inactivity counter: any strobe restarts it; without a strobe these
      // states never change, so the state-change restart is the default 0.
      if (w_counting && !w_any_stb) begin
        if (r_tmo_cnt == C_TMO_LAST) begin
          w_timeout_next = 1'b1;
          w_state_next   = S_IDLE;
        end else begin
          w_tmo_next = r_tmo_cnt + 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_balance   <= INIT_BALANCE;
      r_tries     <= '0;
      r_wd_total  <= '0;
      r_count     <= '0;
      r_entry     <= '0;
      r_tmo_cnt   <= '0;
      r_bal_out   <= '0;
      r_bal_upd   <= 1'b0;
      r_give      <= 1'b0;
      r_insuf     <= 1'b0;
      r_limit     <= 1'b0;
      r_bal_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_incorrect <= 1'b0;
      r_warning   <= 1'b0;
      r_block     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_balance   <= w_balance_next;
      r_tries     <= w_tries_next;
      r_wd_total  <= w_wd_next;
      r_count     <= w_count_next;
      r_entry     <= w_entry_next;
      r_tmo_cnt   <= w_tmo_next;
      r_bal_out   <= w_bal_out_next;
      r_bal_upd   <= w_bal_upd_next;
      r_give      <= w_give_next;
      r_insuf     <= w_insuf_next;
      r_limit     <= w_limit_next;
      r_bal_valid <= w_bal_valid_next;
      r_timeout   <= w_timeout_next;
      r_incorrect <= w_incorrect_next;
      r_warning   <= w_warning_next;
      r_block     <= w_block_next;
    end
  end

  assign balanceUpdated    = r_bal_upd;
  assign giveMoney         = r_give;
  assign insufficientFunds = r_insuf;
  assign limitExceeded     = r_limit;
  assign balanceValid      = r_bal_valid;
  assign balanceOut        = r_bal_out;
  assign incorrectPin      = r_incorrect;
  assign warning           = r_warning;
  assign block             = r_block;
  assign timeout           = r_timeout;

endmodule

// File: tb/tb_atm_controller_param.sv
// tb_atm_controller_param: directed plus randomized sessions against a
// transaction-level model of balance, withdrawal total, tries and flags.
`timescale 1ns/1ps
module tb_atm_controller_param;

  localparam int               PIN_DIGITS   = 4;
  localparam int               MAX_TRIES    = 3;
  localparam int               BAL_W        = 12;
  localparam int               AMT_W        = 10;
  localparam int               TIMEOUT_CYC  = 16;
  localparam logic [AMT_W:0]   WD_LIMIT     = 11'd1000;
  localparam logic [BAL_W-1:0] INIT_BALANCE = 12'd100;
  localparam longint           BAL_MAX      = 4095;
  localparam logic [15:0]      PIN_VAL      = 16'h1234;

  // Pulse vector bits: {updated, give, insufficient, limit, valid, timeout}
  localparam logic [5:0] P_NONE  = 6'b000000;
  localparam logic [5:0] P_UPD   = 6'b100000;
  localparam logic [5:0] P_GIVE  = 6'b010000;
  localparam logic [5:0] P_INSUF = 6'b001000;
  localparam logic [5:0] P_LIM   = 6'b000100;
  localparam logic [5:0] P_VAL   = 6'b000010;
  localparam logic [5:0] P_TMO   = 6'b000001;

  logic             clock = 1'b0;
  logic             reset, receivedCard, stbDigit, stbTransaction, stbAmount, clearLimit;
  logic [3:0]       digit;
  logic [15:0]      pin;
  logic [1:0]       transType;
  logic [AMT_W-1:0] amount;
  logic             balanceUpdated, giveMoney, insufficientFunds, limitExceeded;
  logic             balanceValid, incorrectPin, warning, block, timeout;
  logic [BAL_W-1:0] balanceOut;
  logic [5:0]       w_pulses;

  assign w_pulses = {balanceUpdated, giveMoney, insufficientFunds, limitExceeded, balanceValid, timeout};

  always #5 clock = ~clock;

  atm_controller_param #(
    .PIN_DIGITS(PIN_DIGITS), .MAX_TRIES(MAX_TRIES), .BAL_W(BAL_W), .AMT_W(AMT_W),
    .WD_LIMIT(WD_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC), .INIT_BALANCE(INIT_BALANCE)
  ) dut (
    .clock(clock), .reset(reset), .receivedCard(receivedCard),
    .stbDigit(stbDigit), .digit(digit), .pin(pin),
    .stbTransaction(stbTransaction), .transType(transType),
    .stbAmount(stbAmount), .amount(amount), .clearLimit(clearLimit),
    .balanceUpdated(balanceUpdated), .giveMoney(giveMoney),
    .insufficientFunds(insufficientFunds), .limitExceeded(limitExceeded),
    .balanceValid(balanceValid), .balanceOut(balanceOut),
    .incorrectPin(incorrectPin), .warning(warning), .block(block), .timeout(timeout)
  );

  // Reference model state
  longint m_balance, m_wd, m_bal_out;
  int     m_tries;
  bit     m_inc, m_warn, m_block;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs set beforehand are taken at the edge; strobes drop afterwards
  task automatic tick(input logic [5:0] exp_p);
    @(posedge clock);
    #1;
    stbDigit = 1'b0; stbTransaction = 1'b0; stbAmount = 1'b0; clearLimit = 1'b0;
    check_eq("pulses", 64'(w_pulses), 64'(exp_p));
  endtask

  task automatic check_levels();
    check_eq("incorrectPin", 64'(incorrectPin), 64'(m_inc));
    check_eq("warning", 64'(warning), 64'(m_warn));
    check_eq("block", 64'(block), 64'(m_block));
    check_eq("balanceOut", 64'(balanceOut), 64'(m_bal_out));
  endtask

  task automatic do_reset();
    reset = 1'b1; receivedCard = 1'b0;
    tick(P_NONE);
    reset = 1'b0;
    m_balance = longint'(INIT_BALANCE); m_wd = 0; m_bal_out = 0;
    m_tries = 0; m_inc = 0; m_warn = 0; m_block = 0;
    $display("reset balance=%0d", m_balance);
    check_levels();
  endtask

  task automatic card_in();
    receivedCard = 1'b1;
    tick(P_NONE);
    m_inc = 0; m_warn = 0;
    $display("card inserted tries=%0d", m_tries);
    check_levels();
  endtask

  task automatic leave_idle();
    receivedCard = 1'b0;
    tick(P_NONE);
    tick(P_NONE);
    m_inc = 0; m_warn = 0;
    check_levels();
  endtask

  task automatic enter_pin(input logic [15:0] p, input bit gaps);
    for (int i = 0; i < PIN_DIGITS; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick(P_NONE);
      digit = p[15-4*i -: 4];
      stbDigit = 1'b1;
      tick(P_NONE);
    end
    tick(P_NONE);
    if (p == PIN_VAL) begin
      m_tries = 0; m_inc = 0; m_warn = 0;
    end else begin
      m_tries++;
      m_inc = 1;
      if (m_tries == MAX_TRIES - 1) m_warn = 1;
      if (m_tries == MAX_TRIES) m_block = 1;
    end
    $display("pin %h entered tries=%0d block=%0d", p, m_tries, m_block);
    check_levels();
  endtask

  // Menu transaction: 0 deposit, 1 withdraw, 2 query, 3 end session
  task automatic menu_txn(input logic [1:0] t, input longint amt, input bit zero_first, input bit clr);
    logic [5:0] exp_p;
    transType = t;
    stbTransaction = 1'b1;
    if (t == 2'b10) begin
      m_bal_out = m_balance;
      tick(P_VAL);
      check_levels();
      tick(P_NONE);
      $display("txn query balance=%0d", m_balance);
      return;
    end
    if (t == 2'b11) begin
      tick(P_NONE);
      leave_idle();
      $display("txn end session");
      return;
    end
    tick(P_NONE);
    if (zero_first) begin
      amount = '0; stbAmount = 1'b1;
      tick(P_NONE);
    end
    amount = AMT_W'(amt); stbAmount = 1'b1; clearLimit = clr;
    if (clr) m_wd = 0;
    if (t == 2'b00) begin
      m_balance = (m_balance + amt > BAL_MAX) ? BAL_MAX : m_balance + amt;
      exp_p = P_UPD;
    end else if (amt > m_balance) begin
      exp_p = P_INSUF;
    end else if (m_wd + amt > longint'(WD_LIMIT)) begin
      exp_p = P_LIM;
    end else begin
      m_balance -= amt; m_wd += amt;
      exp_p = P_UPD | P_GIVE;
    end
    tick(exp_p);
    tick(P_NONE);
    $display("txn %s amt=%0d clr=%0d balance=%0d wd=%0d pulses=%b",
             (t == 2'b00) ? "deposit" : "withdraw", amt, clr, m_balance, m_wd, exp_p);
  endtask

  task automatic timeout_in_menu();
    repeat (TIMEOUT_CYC - 1) tick(P_NONE);
    tick(P_TMO);
    leave_idle();
    $display("txn timeout tries=%0d", m_tries);
  endtask

  task automatic drop_in_deposit(input longint amt);
    transType = 2'b00; stbTransaction = 1'b1;
    tick(P_NONE);
    receivedCard = 1'b0; amount = AMT_W'(amt); stbAmount = 1'b1;
    tick(P_NONE);
    tick(P_NONE);
    m_inc = 0; m_warn = 0;
    check_levels();
    $display("txn card removed in deposit amt=%0d balance=%0d", amt, m_balance);
  endtask

  task automatic blocked_sequence();
    receivedCard = 1'b0;
    tick(P_NONE);
    check_levels();
    receivedCard = 1'b1; transType = 2'b10; stbTransaction = 1'b1;
    stbDigit = 1'b1; stbAmount = 1'b1; amount = 10'd5;
    tick(P_NONE);
    check_levels();
    $display("blocked: strobes ignored, block=%0d", block);
    do_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    bit          sess_done, in_menu, dropped;
    int          n_txn, r;

    reset = 1'b1; receivedCard = 1'b0; stbDigit = 1'b0; digit = '0; pin = PIN_VAL;
    stbTransaction = 1'b0; transType = '0; stbAmount = 1'b0; amount = '0; clearLimit = 1'b0;
    tick(P_NONE);
    do_reset();

    // Correct PIN, then the funds and limit corner cases
    card_in();
    enter_pin(PIN_VAL, 1'b0);
    menu_txn(2'b01, 1023, 1'b0, 1'b0);  // > balance and > limit: insufficient only
    menu_txn(2'b10, 0, 1'b0, 1'b0);     // still 100
    menu_txn(2'b00, 1000, 1'b1, 1'b0);  // zero amount ignored first
    menu_txn(2'b01, 400, 1'b1, 1'b0);
    menu_txn(2'b01, 700, 1'b0, 1'b0);   // 400+700 over limit
    menu_txn(2'b01, 700, 1'b0, 1'b1);   // clear applies first
    menu_txn(2'b10, 0, 1'b0, 1'b0);
    repeat (4) menu_txn(2'b00, 1023, 1'b0, 1'b0);
    menu_txn(2'b00, 10, 1'b0, 1'b0);    // saturates at 4095
    menu_txn(2'b10, 0, 1'b0, 1'b0);
    menu_txn(2'b11, 0, 1'b0, 1'b0);

    // Timeout in MENU, then card removal during a deposit
    card_in();
    enter_pin(PIN_VAL, 1'b0);
    timeout_in_menu();
    card_in();
    enter_pin(PIN_VAL, 1'b0);
    drop_in_deposit(300);
    card_in();
    enter_pin(PIN_VAL, 1'b1);
    menu_txn(2'b10, 0, 1'b0, 1'b0);
    menu_txn(2'b11, 0, 1'b0, 1'b0);

    // Three wrong PINs block the card until reset
    card_in();
    enter_pin(16'h1111, 1'b0);
    enter_pin(16'h2222, 1'b0);
    enter_pin(16'h3333, 1'b0);
    blocked_sequence();

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      sess_done = 1'b0; in_menu = 1'b0; dropped = 1'b0;
      card_in();
      while (!sess_done) begin
        if ($urandom_range(0, 3) == 0) begin
          p = 16'($urandom);
          if (p == PIN_VAL) p = ~p;
        end else begin
          p = PIN_VAL;
        end
        enter_pin(p, 1'b1);
        if (p == PIN_VAL) begin
          in_menu = 1'b1; sess_done = 1'b1;
        end else if (m_block) begin
          blocked_sequence(); sess_done = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          leave_idle(); sess_done = 1'b1;
          $display("card removed during PIN entry tries=%0d", m_tries);
        end
      end
      if (in_menu) begin
        n_txn = $urandom_range(1, 6);
        for (int k = 0; k < n_txn && !dropped; k++) begin
          r = $urandom_range(0, 9);
          if (r <= 2) begin
            menu_txn(2'b00, $urandom_range(1, 1023), ($urandom_range(0, 4) == 0), 1'b0);
          end else if (r <= 5) begin
            menu_txn(2'b01, $urandom_range(1, ($urandom_range(0, 1) == 0) ? 300 : 1023),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
          end else if (r <= 7) begin
            menu_txn(2'b10, 0, 1'b0, 1'b0);
          end else if (r == 8) begin
            clearLimit = 1'b1;
            tick(P_NONE);
            m_wd = 0;
            $display("txn clearLimit");
          end else begin
            drop_in_deposit($urandom_range(1, 1023));
            dropped = 1'b1;
          end
        end
        if (!dropped) begin
          menu_txn(2'b10, 0, 1'b0, 1'b0);
          menu_txn(2'b11, 0, 1'b0, 1'b0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/atm_controller_param.md
Name: atm_controller_param

Overview:
- Parametrised next-generation ATM session controller.
- Configurable PIN length, retry limit, balance and amount widths, and an inactivity timeout.
- Adds features over the previous generation: balance query, multiple transactions per card session, a cumulative withdrawal limit, and card-removal abort.
- Sits between the keypad/card-reader front end and the cash dispenser / account display.

Parameters:
- PIN_DIGITS, 4, number of 4-bit PIN digits entered per attempt (1..8).
- MAX_TRIES, 3, consecutive wrong PINs that cause a block (2..15).
- BAL_W, 64, balance register width.
- AMT_W, 32, transaction amount width (AMT_W <= BAL_W).
- WD_LIMIT, 100000, maximum cumulative withdrawal between limit clears (AMT_W+1 bits).
- TIMEOUT_CYC, 1024, idle cycles before a session is aborted.
- INIT_BALANCE, 1524330493, balance loaded at reset.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- receivedCard, in, 1, level; high while a card is inserted.
- stbDigit, in, 1, one-cycle strobe; digit is valid.
- digit, in, 4, keypad digit.
- pin, in, 4*PIN_DIGITS, stored PIN; first digit in the MSBs.
- stbTransaction, in, 1, strobe; transType is valid.
- transType, in, 2, 00 deposit, 01 withdrawal, 10 balance query, 11 end session.
- stbAmount, in, 1, strobe; amount is valid.
- amount, in, AMT_W, transaction amount.
- clearLimit, in, 1, strobe; zeroes the withdrawal accumulator.
- balanceUpdated, out, 1, one-cycle pulse.
- giveMoney, out, 1, one-cycle pulse.
- insufficientFunds, out, 1, one-cycle pulse.
- limitExceeded, out, 1, one-cycle pulse.
- balanceValid, out, 1, one-cycle pulse; balanceOut is valid.
- balanceOut, out, BAL_W, balance snapshot; holds its value between queries.
- incorrectPin, out, 1, level.
- warning, out, 1, level.
- block, out, 1, level.
- timeout, out, 1, one-cycle pulse.

Behaviour:
- Interface: one clock domain on clock; reset is synchronous and active-high. All outputs are registered.
- Reset:
  - state = IDLE; all outputs 0; balanceOut = 0.
  - balance = INIT_BALANCE; tries = 0; wdTotal = 0; digit count = 0; timeout counter = 0.
- States: IDLE, PIN_ENTRY, PIN_CHECK, MENU, DEPOSIT, WITHDRAW, DONE, BLOCKED.
- IDLE:
  - incorrectPin, warning and the digit count are cleared.
  - receivedCard=1 -> PIN_ENTRY next cycle.
- PIN_ENTRY:
  - Each stbDigit shifts digit into the entry register, MSB-first, and increments the count.
  - The cycle after the PIN_DIGITS-th strobe, state = PIN_CHECK.
  - Extra strobes while the count is full are ignored.
- PIN_CHECK (1 cycle):
  - Match -> MENU; tries = 0; incorrectPin = 0; warning = 0.
  - Mismatch -> tries += 1; incorrectPin = 1; count = 0.
    - New tries == MAX_TRIES-1 -> warning = 1.
    - New tries == MAX_TRIES -> BLOCKED, block = 1; otherwise back to PIN_ENTRY.
- MENU, on stbTransaction:
  - 00 -> DEPOSIT; 01 -> WITHDRAW.
  - 10 -> balanceOut = balance and balanceValid pulse (same edge), then DONE.
  - 11 -> IDLE.
- DEPOSIT:
  - stbAmount with amount=0 is ignored.
  - Otherwise balance = balance + amount, saturating at 2^BAL_W-1; balanceUpdated pulse; -> DONE.
- WITHDRAW:
  - stbAmount with amount=0 is ignored.
  - amount > balance -> insufficientFunds pulse, no change. This check has priority over the limit check.
  - Else wdTotal + amount > WD_LIMIT -> limitExceeded pulse, no change.
  - Else balance -= amount; wdTotal += amount; giveMoney and balanceUpdated pulse together.
  - All three cases -> DONE.
- DONE (1 cycle): -> MENU. Multiple transactions per session are allowed.
- Pulse timing: all pulse outputs are high for exactly the cycle following the registering edge.
- BLOCKED:
  - block stays 1 and all strobes are ignored.
  - Card removal does not exit; only reset exits.
- Card removal: receivedCard=0 in any state except IDLE/BLOCKED -> IDLE next cycle. An in-flight transaction is discarded; balance is unchanged.
- Timeout:
  - The counter runs in PIN_ENTRY, MENU, DEPOSIT and WITHDRAW.
  - It resets on any stbDigit, stbTransaction or stbAmount, and on every state change.
  - Reaching TIMEOUT_CYC -> timeout pulse, state = IDLE, tries preserved.
- tries persists across sessions until a correct PIN or reset.
- clearLimit:
  - Accepted in any state.
  - If it coincides with a withdrawal commit, the accumulator ends at that amount (clear applies first).
- Simultaneous strobes: only the strobe relevant to the current state is acted on.
- Reset mid-operation overrides everything on that edge.

Test Plan:
- Card in, digits 1,2,3,4 with pin=16'h1234 -> PIN_CHECK then MENU; incorrectPin=0, warning=0, block=0.
- Three wrong PINs (MAX_TRIES=3):
  - After the first, incorrectPin=1.
  - After the second, warning=1.
  - After the third, block=1.
  - Card removal keeps block=1; reset clears it.
- Withdraw 40000 then 70000 with WD_LIMIT=100000, balance 1524330493:
  - First: giveMoney and balanceUpdated pulse; balance = 1524290493.
  - Second: limitExceeded pulse only.
  - clearLimit, then 70000 again -> giveMoney.
- Withdraw amount > balance with BAL_W=16, balance 100, amount 200 -> insufficientFunds only, even if the limit would also be exceeded; balance stays 100.
- Deposit saturation with BAL_W=8, balance 250, amount 10 -> balance 255; then query -> balanceOut = 255 with a balanceValid pulse; then transType 11 -> IDLE.
- Timeout with TIMEOUT_CYC=16:
  - No strobes for 16 cycles in MENU -> timeout pulse, IDLE.
  - receivedCard drop mid-DEPOSIT -> IDLE, balance unchanged.
